// File: rtl/ccu_ctrl_pkg.sv
// ccu_ctrl_pkg
//   Shared types for the CCU control path.
//   mu_op_e     : operation codes issued by the CCU FSMs to the memory unit.
//   arb_state_e : state of the memory-unit arbiter (ccu_mu_arbiter).
//   idx_bits    : index width helper that never returns 0.
package ccu_ctrl_pkg;

  typedef enum logic [2:0] {
    SEND_AXI_REQ_WRITE_BACK_R,
    SEND_AXI_REQ_WRITE_BACK_W,
    SEND_AXI_REQ_R,
    SEND_AXI_REQ_W,
    SEND_INVALID_ACK_R,
    SEND_INVALID_ACK_W
  } mu_op_e;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_e;

  function automatic int unsigned idx_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ccu_rr_pick.sv
// ccu_rr_pick
//   Combinational cyclic priority pick: returns the first asserted request at
//   index >= i_ptr, wrapping from N-1 back to 0. N need not be a power of 2.
// Ports:
//   i_req   [N-1:0]  request vector
//   i_ptr   [W-1:0]  starting index (must be < N)
//   o_idx   [W-1:0]  picked index (0 when nothing is requested)
//   o_valid          at least one request asserted
module ccu_rr_pick #(
  parameter int unsigned N = 2,
  parameter int unsigned W = 1
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [W-1:0] o_idx,
  output logic         o_valid
);

  always_comb begin
    int unsigned cand;
    cand    = 0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      // Wrap by compare so non-power-of-2 N stays in range.
      cand = 32'(i_ptr) + k;
      if (cand >= N) cand = cand - N;
      if (!o_valid && |(i_req & (N'(1) << cand))) begin
        o_valid = 1'b1;
        o_idx   = W'(cand);
      end
    end
  end

endmodule

// File: rtl/ccu_mu_arbiter.sv
// ccu_mu_arbiter
//   Round-robin arbiter sharing one CCU memory unit between NoRequesters CCU
//   control FSMs. The chosen operation is held (LOCKED) until the memory unit
//   grants it; newer requests never preempt a locked choice.
//   Optional macro CCU_MU_ARB_OUT_REG_EN inserts a one-entry output register:
//   gnt_o then pulses on capture and mu_req_o follows one cycle later.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   req_i/op_i/holder_i/first_responder_i  per-requester operation
//   gnt_o                   one-hot grant back to requesters
//   mu_req_o/mu_op_o/mu_holder_o/mu_first_responder_o/mu_gnt_i  memory unit side
//   sel_idx_o               currently selected requester (trace)
module ccu_mu_arbiter
  import ccu_ctrl_pkg::*;
#(
  parameter int unsigned NoRequesters = 2,
  parameter int unsigned NoMstPorts   = 4,
  parameter type         slv_req_t    = logic,
  localparam int unsigned ReqIdxBits  = idx_bits(NoRequesters),
  localparam int unsigned MstIdxBits  = $clog2(NoMstPorts)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NoRequesters-1:0] req_i,
  input  mu_op_e                  op_i              [NoRequesters],
  input  slv_req_t                holder_i          [NoRequesters],
  input  logic [MstIdxBits-1:0]   first_responder_i [NoRequesters],
  output logic [NoRequesters-1:0] gnt_o,
  output logic                    mu_req_o,
  output mu_op_e                  mu_op_o,
  output slv_req_t                mu_holder_o,
  output logic [MstIdxBits-1:0]   mu_first_responder_o,
  input  logic                    mu_gnt_i,
  output logic [ReqIdxBits-1:0]   sel_idx_o
);

  logic [ReqIdxBits-1:0] r_rr_ptr;
  logic [ReqIdxBits-1:0] w_rr_nxt;
  logic [ReqIdxBits-1:0] w_pick_idx;
  logic                  w_pick_vld;

  function automatic logic [ReqIdxBits-1:0] f_next(input logic [ReqIdxBits-1:0] s);
    return (32'(s) == NoRequesters - 1) ? '0 : ReqIdxBits'(s + 1'b1);
  endfunction

  ccu_rr_pick #(
    .N(NoRequesters),
    .W(ReqIdxBits)
  ) u_pick (
    .i_req  (req_i),
    .i_ptr  (r_rr_ptr),
    .o_idx  (w_pick_idx),
    .o_valid(w_pick_vld)
  );

`ifndef CCU_MU_ARB_OUT_REG_EN

  arb_state_e            r_state, w_state_nxt;
  logic [ReqIdxBits-1:0] r_sel_q, w_sel_q_nxt;
  logic [ReqIdxBits-1:0] w_sel;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= ARB_IDLE;
      r_sel_q  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_sel_q  <= w_sel_q_nxt;
      r_rr_ptr <= w_rr_nxt;
    end
  end

  // Outputs are forced low while rst_i is high so a reset during LOCKED
  // drops the request immediately even if requesters keep req_i asserted.
  always_comb begin
    w_state_nxt          = r_state;
    w_sel_q_nxt          = r_sel_q;
    w_rr_nxt             = r_rr_ptr;
    w_sel                = (r_state == ARB_LOCKED) ? r_sel_q : w_pick_idx;
    gnt_o                = '0;
    mu_req_o             = 1'b0;
    mu_op_o              = mu_op_e'('0);
    mu_holder_o          = '0;
    mu_first_responder_o = '0;
    sel_idx_o            = '0;
    if (!rst_i) begin
      unique case (r_state)
        ARB_IDLE: begin
          if (w_pick_vld) begin
            mu_req_o             = 1'b1;
            mu_op_o              = op_i[w_sel];
            mu_holder_o          = holder_i[w_sel];
            mu_first_responder_o = first_responder_i[w_sel];
            sel_idx_o            = w_sel;
            if (mu_gnt_i) begin
              gnt_o[w_sel] = 1'b1;
              w_rr_nxt     = f_next(w_sel);
            end else begin
              w_sel_q_nxt = w_sel;
              w_state_nxt = ARB_LOCKED;
            end
          end
        end
        ARB_LOCKED: begin
          mu_req_o             = req_i[w_sel];
          mu_op_o              = op_i[w_sel];
          mu_holder_o          = holder_i[w_sel];
          mu_first_responder_o = first_responder_i[w_sel];
          sel_idx_o            = w_sel;
          if (!req_i[w_sel]) begin
            // Requester withdrew: abandon without grant or pointer move.
            w_state_nxt = ARB_IDLE;
          end else if (mu_gnt_i) begin
            gnt_o[w_sel] = 1'b1;
            w_rr_nxt     = f_next(w_sel);
            w_state_nxt  = ARB_IDLE;
          end
        end
        default: w_state_nxt = ARB_IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (!rst_i && r_state == ARB_LOCKED)
      assert (req_i[r_sel_q])
      else $error("ccu_mu_arbiter: requester %0d dropped req while locked", r_sel_q);
  end
`endif

`else

  logic                  r_vld;
  mu_op_e                r_op;
  slv_req_t              r_holder;
  logic [MstIdxBits-1:0] r_resp;
  logic [ReqIdxBits-1:0] r_sel;
  logic                  w_accept;

  // Register takes a new winner when empty or draining this cycle.
  assign w_accept = !r_vld || mu_gnt_i;

  always_comb begin
    gnt_o    = '0;
    w_rr_nxt = r_rr_ptr;
    if (!rst_i && w_accept && w_pick_vld) begin
      gnt_o[w_pick_idx] = 1'b1;
      w_rr_nxt          = f_next(w_pick_idx);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_vld    <= 1'b0;
      r_op     <= mu_op_e'('0);
      r_holder <= '0;
      r_resp   <= '0;
      r_sel    <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_rr_ptr <= w_rr_nxt;
      if (w_accept) begin
        r_vld <= w_pick_vld;
        if (w_pick_vld) begin
          r_op     <= op_i[w_pick_idx];
          r_holder <= holder_i[w_pick_idx];
          r_resp   <= first_responder_i[w_pick_idx];
          r_sel    <= w_pick_idx;
        end
      end
    end
  end

  always_comb begin
    mu_req_o             = r_vld;
    mu_op_o              = r_vld ? r_op : mu_op_e'('0);
    mu_holder_o          = r_vld ? r_holder : '0;
    mu_first_responder_o = r_vld ? r_resp : '0;
    sel_idx_o            = r_sel;
  end

`endif

endmodule

// File: tb/tb_ccu_mu_arbiter.sv
module tb_ccu_mu_arbiter;
  import ccu_ctrl_pkg::*;

  typedef logic [7:0] hold_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Two-requester instance
  logic [1:0] req;
  mu_op_e     op   [2];
  hold_t      hold [2];
  logic [1:0] fr   [2];
  logic [1:0] gnt;
  logic       mreq;
  mu_op_e     mop;
  hold_t      mhold;
  logic [1:0] mfr;
  logic       mgnt;
  logic       sel;

  // Three-requester instance
  logic [2:0] req3;
  mu_op_e     op3   [3];
  hold_t      hold3 [3];
  logic [1:0] fr3   [3];
  logic [2:0] gnt3;
  logic       mreq3;
  mu_op_e     mop3;
  hold_t      mhold3;
  logic [1:0] mfr3;
  logic       mgnt3;
  logic [1:0] sel3;

  int checks = 0;
  int errors = 0;

  ccu_mu_arbiter #(.NoRequesters(2), .NoMstPorts(4), .slv_req_t(hold_t)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .op_i(op), .holder_i(hold),
    .first_responder_i(fr), .gnt_o(gnt), .mu_req_o(mreq), .mu_op_o(mop),
    .mu_holder_o(mhold), .mu_first_responder_o(mfr), .mu_gnt_i(mgnt),
    .sel_idx_o(sel)
  );

  ccu_mu_arbiter #(.NoRequesters(3), .NoMstPorts(4), .slv_req_t(hold_t)) dut3 (
    .clk_i(clk), .rst_i(rst), .req_i(req3), .op_i(op3), .holder_i(hold3),
    .first_responder_i(fr3), .gnt_o(gnt3), .mu_req_o(mreq3), .mu_op_o(mop3),
    .mu_holder_o(mhold3), .mu_first_responder_o(mfr3), .mu_gnt_i(mgnt3),
    .sel_idx_o(sel3)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] act, exp;
    rst  = 1'b1;
    req  = 2'b11;
    mgnt = 1'b1;
    #1;
    act = {mreq, gnt, sel, mhold};
    exp = {1'b0, 2'b00, 1'b0, 8'h00};
    checks++;
    if (act !== exp) begin errors++; $display("FAIL reset_outputs: got %h expected %h", act, exp); end
    act = {mreq3, gnt3, sel3};
    exp = {1'b0, 3'b000, 2'd0};
    checks++;
    if (act !== exp) begin errors++; $display("FAIL reset_outputs3: got %h expected %h", act, exp); end
    req  = 2'b00;
    mgnt = 1'b0;
    repeat (2) next_cycle();
    rst = 1'b0;
    next_cycle();
  endtask

`ifndef CCU_MU_ARB_OUT_REG_EN

  task automatic test_passthrough();
    logic [31:0] act, exp;
    req = 2'b01; mgnt = 1'b1; #1;
    act = {mreq, gnt, mop, mhold, mfr, sel};
    exp = {1'b1, 2'b01, SEND_AXI_REQ_R, 8'hA5, 2'd2, 1'b0};
    checks++;
    if (act !== exp) begin errors++; $display("FAIL pass_first: got %h expected %h", act, exp); end
    next_cycle();
    req = 2'b11; #1;
    act = {mreq, gnt, mop, mhold, mfr, sel};
    exp = {1'b1, 2'b10, SEND_AXI_REQ_W, 8'h3C, 2'd1, 1'b1};
    checks++;
    if (act !== exp) begin errors++; $display("FAIL pass_rr_ptr1: got %h expected %h", act, exp); end
    next_cycle();
    req = 2'b00; #1;
    act = {mreq, gnt, mhold};
    exp = {1'b0, 2'b00, 8'h00};
    checks++;
    if (act !== exp) begin errors++; $display("FAIL pass_idle: got %h expected %h", act, exp); end
    mgnt = 1'b0;
    next_cycle();
  endtask

  task automatic test_locked();
    logic [31:0] act, exp;
    req = 2'b11; mgnt = 1'b0; #1;
    act = {mreq, gnt, mhold, sel};
    exp = {1'b1, 2'b00, 8'hA5, 1'b0};
    checks++;
    if (act !== exp) begin errors++; $display("FAIL lock_start: got %h expected %h", act, exp); end
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      act = {mreq, gnt, mhold, sel};
      exp = {1'b1, 2'b00, 8'hA5, 1'b0};
      checks++;
      if (act !== exp) begin errors++; $display("FAIL lock_hold%0d: got %h expected %h", i, act, exp); end
      next_cycle();
    end
    mgnt = 1'b1; #1;
    act = {mreq, gnt, mhold, sel};
    exp = {1'b1, 2'b01, 8'hA5, 1'b0};
    checks++;
    if (act !== exp) begin errors++; $display("FAIL lock_grant: got %h expected %h", act, exp); end
    next_cycle();
    act = {mreq, gnt, mhold, sel};
    exp = {1'b1, 2'b10, 8'h3C, 1'b1};
    checks++;
    if (act !== exp) begin errors++; $display("FAIL lock_next_winner: got %h expected %h", act, exp); end
    next_cycle();
    req = 2'b00; mgnt = 1'b0;
    next_cycle();
  endtask

  task automatic test_hold_stable();
    logic [31:0] act, exp;
    req = 2'b10; mgnt = 1'b0; #1;
    act = {mreq, gnt, mhold, mfr, sel};
    exp = {1'b1, 2'b00, 8'h3C, 2'd1, 1'b1};
    checks++;
    if (act !== exp) begin errors++; $display("FAIL stable_start: got %h expected %h", act, exp); end
    next_cycle();
    req = 2'b11;
    for (int i = 0; i < 3; i++) begin
      #1;
      act = {mreq, gnt, mhold, mfr, sel};
      exp = {1'b1, 2'b00, 8'h3C, 2'd1, 1'b1};
      checks++;
      if (act !== exp) begin errors++; $display("FAIL stable_hold%0d: got %h expected %h", i, act, exp); end
      next_cycle();
    end
    mgnt = 1'b1; #1;
    act = {mreq, gnt, mhold, sel};
    exp = {1'b1, 2'b10, 8'h3C, 1'b1};
    checks++;
    if (act !== exp) begin errors++; $display("FAIL stable_grant: got %h expected %h", act, exp); end
    next_cycle();
    act = {mreq, gnt, mhold, sel};
    exp = {1'b1, 2'b01, 8'hA5, 1'b0};
    checks++;
    if (act !== exp) begin errors++; $display("FAIL stable_wrap: got %h expected %h", act, exp); end
    next_cycle();
    req = 2'b00; mgnt = 1'b0;
    next_cycle();
  endtask

  task automatic test_reset_locked();
    logic [31:0] act, exp;
    req = 2'b11; mgnt = 1'b0; #1;
    act = {mreq, gnt, sel};
    exp = {1'b1, 2'b00, 1'b1};
    checks++;
    if (act !== exp) begin errors++; $display("FAIL rstlock_start: got %h expected %h", act, exp); end
    next_cycle();
    rst = 1'b1; mgnt = 1'b1; #1;
    act = {mreq, gnt, sel, mhold};
    exp = {1'b0, 2'b00, 1'b0, 8'h00};
    checks++;
    if (act !== exp) begin errors++; $display("FAIL rstlock_async: got %h expected %h", act, exp); end
    next_cycle();
    rst = 1'b0; #1;
    act = {mreq, gnt, sel, mhold};
    exp = {1'b1, 2'b01, 1'b0, 8'hA5};
    checks++;
    if (act !== exp) begin errors++; $display("FAIL rstlock_ptr0: got %h expected %h", act, exp); end
    next_cycle();
    req = 2'b00; mgnt = 1'b0;
    next_cycle();
  endtask

  task automatic test_three();
    logic [31:0] act, exp;
    logic [2:0] t_req [9] = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111,
                              3'b110, 3'b110, 3'b110};
    logic [2:0] t_gnt [9] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100,
                              3'b010, 3'b100, 3'b010};
    logic [1:0] t_sel [9] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1};
    hold_t      t_hld [9] = '{8'h10, 8'h11, 8'h12, 8'h10, 8'h11, 8'h12,
                              8'h11, 8'h12, 8'h11};
    mgnt3 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      req3 = t_req[i]; #1;
      act = {mreq3, gnt3, sel3, mhold3};
      exp = {1'b1, t_gnt[i], t_sel[i], t_hld[i]};
      checks++;
      if (act !== exp) begin errors++; $display("FAIL three_rr%0d: got %h expected %h", i, act, exp); end
      next_cycle();
    end
    req3 = 3'b000; mgnt3 = 1'b0;
    next_cycle();
  endtask

`else

  task automatic test_outreg();
    logic [31:0] act, exp;
    logic [1:0] t_gnt [4] = '{2'b10, 2'b01, 2'b10, 2'b00};
    hold_t      t_hld [4] = '{8'hA5, 8'h3C, 8'hA5, 8'h3C};
    req = 2'b01; mgnt = 1'b1; #1;
    act = {mreq, gnt};
    exp = {1'b0, 2'b01};
    checks++;
    if (act !== exp) begin errors++; $display("FAIL outreg_capture: got %h expected %h", act, exp); end
    next_cycle();
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) req = 2'b00;
      #1;
      act = {mreq, gnt, mhold};
      exp = {1'b1, t_gnt[i], t_hld[i]};
      checks++;
      if (act !== exp) begin errors++; $display("FAIL outreg_stream%0d: got %h expected %h", i, act, exp); end
      next_cycle();
    end
    act = {mreq, gnt, mhold};
    exp = {1'b0, 2'b00, 8'h00};
    checks++;
    if (act !== exp) begin errors++; $display("FAIL outreg_drained: got %h expected %h", act, exp); end
    mgnt = 1'b0;
    next_cycle();
  endtask

`endif

  initial begin
    rst   = 1'b1;
    req   = '0;
    mgnt  = 1'b0;
    req3  = '0;
    mgnt3 = 1'b0;
    op[0] = SEND_AXI_REQ_R;  hold[0] = 8'hA5; fr[0] = 2'd2;
    op[1] = SEND_AXI_REQ_W;  hold[1] = 8'h3C; fr[1] = 2'd1;
    op3[0] = SEND_INVALID_ACK_R; hold3[0] = 8'h10; fr3[0] = 2'd0;
    op3[1] = SEND_INVALID_ACK_W; hold3[1] = 8'h11; fr3[1] = 2'd1;
    op3[2] = SEND_AXI_REQ_WRITE_BACK_R; hold3[2] = 8'h12; fr3[2] = 2'd3;

    test_reset();
`ifndef CCU_MU_ARB_OUT_REG_EN
    test_passthrough();
    test_locked();
    test_hold_stable();
    test_reset_locked();
    test_three();
`else
    test_outreg();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
